// File: rtl/snake_step_controller_if.sv
// Control/status bundle between the game logic and the snake step controller.
// Latency: none (wires only).
// Backpressure: none; buttons are single-cycle pulses and step/wrap are single-cycle pulses.
interface snake_step_controller_if #(
    parameter int TICK_W = 24
);
    logic              run;
    logic [TICK_W-1:0] tick_period;
    logic [4:0]        max_x;
    logic [4:0]        max_y;
    logic              btn_up;
    logic              btn_down;
    logic              btn_left;
    logic              btn_right;
    logic [4:0]        head_x;
    logic [4:0]        head_y;
    logic [1:0]        dir;
    logic              step;
    logic              wrap;

    // Game/testbench side: drives controls and buttons, observes the head.
    modport master (
        output run, tick_period, max_x, max_y,
        output btn_up, btn_down, btn_left, btn_right,
        input  head_x, head_y, dir, step, wrap
    );

    // Controller side.
    modport slave (
        input  run, tick_period, max_x, max_y,
        input  btn_up, btn_down, btn_left, btn_right,
        output head_x, head_y, dir, step, wrap
    );
endinterface

// File: rtl/snake_step_controller.sv
// Game-tick divider, direction arbiter and wrapping 5-bit head position for the snake.
// Latency: step pulses every max(tick_period,1)+1 cycles while run is high; head/dir visible the cycle after step.
// Backpressure: none; run low pauses and restarts the period. Optional reverse blocking: SNAKE_REVERSE_BLOCK_EN.
module snake_step_controller #(
    parameter int TICK_W = 24
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    snake_step_controller_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic       wrap;
    } move_t;

    // One cell of movement in direction d with wrap against the per-axis maximum.
    // A coordinate already beyond its maximum is treated as out of range and wraps.
    function automatic move_t do_move(input logic [1:0] d,
                                      input logic [4:0] x,
                                      input logic [4:0] y,
                                      input logic [4:0] mx,
                                      input logic [4:0] my);
        move_t m;
        m.x    = x;
        m.y    = y;
        m.wrap = 1'b0;
        case (d)
            DIR_UP: begin
                if (y == 5'd0 || y > my) begin
                    m.y    = my;
                    m.wrap = 1'b1;
                end else begin
                    m.y = y - 5'd1;
                end
            end
            DIR_DOWN: begin
                if (y >= my) begin
                    m.y    = 5'd0;
                    m.wrap = 1'b1;
                end else begin
                    m.y = y + 5'd1;
                end
            end
            DIR_LEFT: begin
                if (x == 5'd0 || x > mx) begin
                    m.x    = mx;
                    m.wrap = 1'b1;
                end else begin
                    m.x = x - 5'd1;
                end
            end
            default: begin
                if (x >= mx) begin
                    m.x    = 5'd0;
                    m.wrap = 1'b1;
                end else begin
                    m.x = x + 5'd1;
                end
            end
        endcase
        return m;
    endfunction

    state_t            state_q;
    logic [TICK_W-1:0] div_q;
    logic [4:0]        head_x_q;
    logic [4:0]        head_y_q;
    logic [1:0]        dir_q;
    logic [1:0]        pend_q;
    logic [1:0]        pend_d;
    logic              step_q;
    logic              wrap_q;
    // Move staged on entry to STEP and committed as it ends, so wrap and the
    // committed head always describe the same move.
    logic [4:0]        nxt_x_q;
    logic [4:0]        nxt_y_q;
    logic [1:0]        nxt_dir_q;

    logic [TICK_W-1:0] period_m1;
    logic              req_vld;
    logic [1:0]        req_dir;
    logic              req_ok;
    move_t             mv_entry;

    // Terminal divider count; a period of zero behaves as one.
    always_comb begin
        period_m1 = '0;
        if (bus.tick_period != '0) begin
            period_m1 = bus.tick_period - TICK_W'(1);
        end
    end

    // Fixed-priority pick among same-cycle buttons, then optional reversal filter.
    always_comb begin
        req_vld = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
        req_dir = DIR_RIGHT;
        if (bus.btn_up) begin
            req_dir = DIR_UP;
        end else if (bus.btn_down) begin
            req_dir = DIR_DOWN;
        end else if (bus.btn_left) begin
            req_dir = DIR_LEFT;
        end
`ifdef SNAKE_REVERSE_BLOCK_EN
        // Opposite pairs differ only in bit 0; checked against the committed dir.
        req_ok = req_vld && ((req_dir ^ dir_q) != 2'b01);
`else
        req_ok = req_vld;
`endif
        pend_d = req_ok ? req_dir : pend_q;
    end

    // Move that the upcoming step will perform, using the freshest pending direction.
    always_comb begin
        mv_entry = do_move(pend_d, head_x_q, head_y_q, bus.max_x, bus.max_y);
    end

    // Tick FSM with registered step/wrap, head, direction and pending request.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            head_x_q  <= 5'd0;
            head_y_q  <= 5'd0;
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
            nxt_x_q   <= 5'd0;
            nxt_y_q   <= 5'd0;
            nxt_dir_q <= DIR_RIGHT;
        end else begin
            pend_q <= pend_d;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    div_q <= '0;
                    if (bus.run) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!bus.run) begin
                        state_q <= S_IDLE;
                        div_q   <= '0;
                    end else if (div_q >= period_m1) begin
                        // >= so a period lowered below the current count still fires.
                        state_q   <= S_STEP;
                        div_q     <= '0;
                        step_q    <= 1'b1;
                        wrap_q    <= mv_entry.wrap;
                        nxt_x_q   <= mv_entry.x;
                        nxt_y_q   <= mv_entry.y;
                        nxt_dir_q <= pend_d;
                    end else begin
                        div_q <= div_q + TICK_W'(1);
                    end
                end
                S_STEP: begin
                    head_x_q <= nxt_x_q;
                    head_y_q <= nxt_y_q;
                    dir_q    <= nxt_dir_q;
                    state_q  <= bus.run ? S_RUN : S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    div_q   <= '0;
                end
            endcase
        end
    end

    assign bus.head_x = head_x_q;
    assign bus.head_y = head_y_q;
    assign bus.dir    = dir_q;
    assign bus.step   = step_q;
    assign bus.wrap   = wrap_q;

endmodule
